dm163_rx_model: RTL
===================

Name: dm163_rx_model

Overview:
- Receive-side model of the DM163 serial interface, i.e. the chip end of the colorshield link.
- Samples the serial lines (s_sda, s_clk, lat, sb, s_rst) together with the channel row-select, and shifts bits in.
- On each latch, loads the 144-bit gamma bank or one 8-pixel row of PWM data into an 8x8x24 frame store.
- Exposes a registered read port, frame/row status and sticky protocol-error flags. Used as a synthesizable bench/loopback checker for the colorshield driver.

Parameters:
- N_GAMMA, 144, gamma bank length in bits (24 channels x 6 bits).
- N_PWM, 192, PWM bank length in bits (24 channels x 8 bits).
- CNT_W, 8, width of the saturating bit counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_sda  in  1  serial data from driver.
- s_clk  in  1  serial clock from driver; shift on its rising edge.
- s_rst  in  1  chip reset, active-low.
- lat  in  1  latch; action on its rising edge.
- sb  in  1  bank select: 0 = gamma bank, 1 = PWM bank.
- channel  in  8  one-hot row select, sampled at latch.
- rd_addr  in  6  {row[5:3], col[2:0]}.
- rd_data  out  24  {R,G,B} of the addressed pixel; one-cycle latency.
- gamma_data  out  144  last latched gamma bank.
- gamma_valid  out  1  high after the first correct gamma latch.
- row_valid  out  1  one-cycle pulse on each accepted PWM row latch.
- row_idx  out  3  index of the last accepted row.
- frame_cnt  out  16  count of row-7 captures, wraps at 2^16.
- err_len  out  1  sticky: bit count at latch did not match the bank length.
- err_chan  out  1  sticky: channel not one-hot at a PWM latch.

Behaviour:
- Reset (rst=1 at a clk edge):
  - shift register, bit_cnt, gamma_data, frame_cnt and row_idx clear to 0.
  - gamma_valid, row_valid, err_len, err_chan and rd_data clear to 0.
  - Frame store contents are not cleared.
- Edge detection:
  - s_sda, s_clk, lat, sb and channel pass through the same sampling pipeline.
  - A rising edge is prev=0, cur=1 of the sampled s_clk or lat.
- On an s_clk rising edge:
  - sr <= {sr[190:0], sda_sampled}, so the MSB is first in.
  - bit_cnt increments and saturates at 2^CNT_W-1.
- On a lat rising edge, with sb sampled in the same cycle:
  - sb=0: gamma_data <= sr[143:0]. gamma_valid <= 1 only if bit_cnt==144, else err_len <= 1 and gamma_valid is unchanged.
  - sb=1, bit_cnt==192 and channel one-hot: write the row (see the next item), row_idx <= index of the set bit, and row_valid pulses one cycle. If that row is 7, frame_cnt increments.
  - sb=1, bit_cnt!=192: err_len <= 1 and the store is not written.
  - sb=1, channel not one-hot (zero or multiple bits): err_chan <= 1 and the store is not written. Both errors may set in the same cycle.
  - In every case bit_cnt <= 0. sr is kept.
- Row write: column c gets sr[24c+23:24c], so the first shifted pixel lands in column 7.
- s_clk and lat rising in the same cycle: apply the shift first, then latch using the updated sr and bit_cnt.
- Sampled s_rst=0:
  - sr and bit_cnt held at 0, gamma_valid <= 0, and edges are ignored.
  - Error flags, frame store and frame_cnt are kept.
  - On release, the first s_clk edge is bit 1.
- Read port: rd_data <= store[rd_addr] every cycle.
  - A read of the row being written in the same cycle returns the old data.
- rst has priority over all other events.

Optional Feature:
- Macro DM163_RX_SYNC_EN.
- When defined: every serial input (s_sda, s_clk, lat, sb, s_rst, channel) passes through a 2-flop synchronizer before edge detection. Response appears 3 clk cycles after the input edge.
- When undefined: inputs are registered once. Response appears 2 cycles after the edge, and the inputs must already be synchronous to clk.
- Functional results are identical either way; only the latency differs.

Test Plan:
- Shift 144 bits of {8{6'd63,6'd63,6'd63}} with sb=0, then pulse lat -> gamma_data all ones, gamma_valid=1, err_len=0.
- sb=1, channel=8'h04, shift 192 bits with column 7 = 24'hFF0000 and the others 0, pulse lat -> row_valid one pulse, row_idx=2; read 6'o27 -> 24'hFF0000 next cycle; read 6'o20 -> 0.
- Eight full rows with channel 01,02,..,80 -> frame_cnt=1; every rd_addr matches the driven pixel.
- PWM latch after 191 bits -> err_len=1, no row_valid, store unchanged. Then channel=8'h03 with 192 bits -> err_chan=1.
- Hold s_rst=0 mid-shift at bit 100, release, shift 192 bits and latch -> accepted with no err_len; gamma_valid=0.
- Assert rst mid-frame -> all outputs 0 on the next cycle; store contents read back unchanged.

Source files
------------

// File: rtl/dm163_rx_model.sv
// ============================================================================
// Module   : dm163_rx_model
// Purpose  : Receive-side (chip end) model of the DM163 serial link: shifts in
//            gamma/PWM banks and captures PWM rows into an 8x8x24 frame store.
//            Define DM163_RX_SYNC_EN to put a 2-flop synchronizer on the inputs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dm163_rx_model #(
  parameter int N_GAMMA = 144,
  parameter int N_PWM   = 192,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_sda,
  input  logic               s_clk,
  input  logic               s_rst,
  input  logic               lat,
  input  logic               sb,
  input  logic [7:0]         channel,
  input  logic [5:0]         rd_addr,
  output logic [23:0]        rd_data,
  output logic [N_GAMMA-1:0] gamma_data,
  output logic               gamma_valid,
  output logic               row_valid,
  output logic [2:0]         row_idx,
  output logic [15:0]        frame_cnt,
  output logic               err_len,
  output logic               err_chan
);

`ifdef DM163_RX_SYNC_EN
  localparam int c_sync_stages = 2;
`else
  localparam int c_sync_stages = 1;
`endif
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;
  localparam logic [CNT_W-1:0] c_gamma_cnt = CNT_W'(N_GAMMA);
  localparam logic [CNT_W-1:0] c_pwm_cnt   = CNT_W'(N_PWM);

  logic [12:0]        in_pipe_q [c_sync_stages];
  logic               sclk_prev_q, lat_prev_q;
  logic [N_PWM-1:0]   sr_q, sr_d, w_sr_sh;
  logic [CNT_W-1:0]   cnt_q, cnt_d, w_cnt_sh;
  logic [N_GAMMA-1:0] gamma_q, gamma_d;
  logic               gv_q, gv_d, rv_q, rv_d, el_q, el_d, ec_q, ec_d;
  logic [2:0]         ri_q, ri_d;
  logic [15:0]        fc_q, fc_d;
  logic [23:0]        rd_q;
  logic [23:0]        store_q [64];

  logic [12:0] w_in, w_smp;
  logic        w_sda, w_sclk, w_lat, w_sb, w_srst_n;
  logic [7:0]  w_chan;
  logic [2:0]  w_row;
  logic        w_onehot, w_sclk_rise, w_lat_rise, w_wr_en;

  // All serial inputs share one pipeline so they stay mutually aligned.
  assign w_in = {channel, s_rst, sb, lat, s_clk, s_sda};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_sync_stages; i++) in_pipe_q[i] <= '0;
      sclk_prev_q <= 1'b0;
      lat_prev_q  <= 1'b0;
    end else begin
      in_pipe_q[0] <= w_in;
      for (int i = 1; i < c_sync_stages; i++) in_pipe_q[i] <= in_pipe_q[i-1];
      sclk_prev_q <= w_sclk;
      lat_prev_q  <= w_lat;
    end
  end

  assign w_smp    = in_pipe_q[c_sync_stages-1];
  assign w_sda    = w_smp[0];
  assign w_sclk   = w_smp[1];
  assign w_lat    = w_smp[2];
  assign w_sb     = w_smp[3];
  assign w_srst_n = w_smp[4];
  assign w_chan   = w_smp[12:5];

  assign w_sclk_rise = w_sclk & ~sclk_prev_q & w_srst_n;
  assign w_lat_rise  = w_lat & ~lat_prev_q & w_srst_n;
  assign w_onehot    = $onehot(w_chan);

  always_comb begin
    w_row = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_chan[i]) w_row = 3'(i);
    end
  end

  // Shift happens before latch evaluation, so a same-cycle latch sees the new bit.
  always_comb begin
    w_sr_sh  = sr_q;
    w_cnt_sh = cnt_q;
    if (w_sclk_rise) begin
      w_sr_sh = {sr_q[N_PWM-2:0], w_sda};
      if (cnt_q != c_cnt_max) w_cnt_sh = cnt_q + 1'b1;
    end
  end

  always_comb begin
    sr_d    = w_sr_sh;
    cnt_d   = w_cnt_sh;
    gamma_d = gamma_q;
    gv_d    = gv_q;
    rv_d    = 1'b0;
    ri_d    = ri_q;
    fc_d    = fc_q;
    el_d    = el_q;
    ec_d    = ec_q;
    w_wr_en = 1'b0;
    if (!w_srst_n) begin
      sr_d  = '0;
      cnt_d = '0;
      gv_d  = 1'b0;
    end else if (w_lat_rise) begin
      cnt_d = '0;
      if (!w_sb) begin
        gamma_d = w_sr_sh[N_GAMMA-1:0];
        if (w_cnt_sh == c_gamma_cnt) gv_d = 1'b1;
        else                         el_d = 1'b1;
      end else begin
        if (w_cnt_sh != c_pwm_cnt) el_d = 1'b1;
        if (!w_onehot)             ec_d = 1'b1;
        if (w_cnt_sh == c_pwm_cnt && w_onehot) begin
          w_wr_en = 1'b1;
          rv_d    = 1'b1;
          ri_d    = w_row;
          if (w_row == 3'd7) fc_d = fc_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      gamma_q <= '0;
      gv_q    <= 1'b0;
      rv_q    <= 1'b0;
      ri_q    <= '0;
      fc_q    <= '0;
      el_q    <= 1'b0;
      ec_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      gamma_q <= gamma_d;
      gv_q    <= gv_d;
      rv_q    <= rv_d;
      ri_q    <= ri_d;
      fc_q    <= fc_d;
      el_q    <= el_d;
      ec_q    <= ec_d;
      rd_q    <= store_q[rd_addr];
    end
  end

  // Frame store is never cleared; column 7 holds the first pixel shifted in.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      for (int c = 0; c < 8; c++) store_q[{w_row, 3'(c)}] <= w_sr_sh[24*c +: 24];
    end
  end

  assign rd_data     = rd_q;
  assign gamma_data  = gamma_q;
  assign gamma_valid = gv_q;
  assign row_valid   = rv_q;
  assign row_idx     = ri_q;
  assign frame_cnt   = fc_q;
  assign err_len     = el_q;
  assign err_chan    = ec_q;

endmodule

`default_nettype wire
